// File: rtl/dispatch_alloc_ctrl_pkg.sv
// Shared record/state types and default sizing for the dispatch allocation controller.
package dispatch_alloc_ctrl_pkg;
    localparam int ROB_DEPTH_DEF = 32;
    localparam int LQ_DEPTH_DEF  = 8;
    localparam int SQ_DEPTH_DEF  = 8;
    localparam int BQ_DEPTH_DEF  = 8;
    localparam int ID_W_DEF      = 8;

    typedef struct packed {
        logic lq;
        logic sq;
        logic bq;
    } alloc_rec_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } alloc_state_e;

    // Credit count after one grant and up to two releases; negative means underflow.
    function automatic int creditNet(input int cnt, input logic inc, input logic decA, input logic decB);
        return cnt + int'(inc) - int'(decA) - int'(decB);
    endfunction
endpackage

// File: rtl/dispatch_alloc_ctrl_alloc_ring.sv
// Per-slot resource record file: one write port at tail, async reads at head and tail-1.
module alloc_ring
    import dispatch_alloc_ctrl_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH_DEF,
    parameter int IDX_W = $clog2(ROB_DEPTH_DEF)
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [IDX_W-1:0] wrIdx_i,
    input  alloc_rec_t       wrData_i,
    input  logic [IDX_W-1:0] headIdx_i,
    output alloc_rec_t       headRec_o,
    input  logic [IDX_W-1:0] tailIdx_i,
    output alloc_rec_t       tailRec_o
);
    // Contents of unoccupied slots are don't-care, so the array needs no reset.
    alloc_rec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrIdx_i] <= wrData_i;
        end
    end

    assign headRec_o = mem[headIdx_i];
    assign tailRec_o = mem[tailIdx_i];
endmodule

// File: rtl/dispatch_alloc_ctrl.sv
// Grants ROB slots and LQ/SQ/BQ credits at dispatch, frees them at commit, and walks back squashed records.
module dispatch_alloc_ctrl
    import dispatch_alloc_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int LQ_DEPTH  = LQ_DEPTH_DEF,
    parameter int SQ_DEPTH  = SQ_DEPTH_DEF,
    parameter int BQ_DEPTH  = BQ_DEPTH_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         alloc_valid_i,
    input  logic [ID_W-1:0]              alloc_id_i,
    input  logic                         alloc_uses_lq_i,
    input  logic                         alloc_uses_sq_i,
    input  logic                         alloc_uses_bq_i,
    output logic                         alloc_ready_o,
    input  logic                         commit_valid_i,
    input  logic                         squash_valid_i,
    input  logic [ID_W-1:0]              squash_id_i,
    output logic [$clog2(ROB_DEPTH):0]   rob_cnt_o,
    output logic [$clog2(LQ_DEPTH):0]    lq_cnt_o,
    output logic [$clog2(SQ_DEPTH):0]    sq_cnt_o,
    output logic [$clog2(BQ_DEPTH):0]    bq_cnt_o,
    output logic                         recovering_o,
    output logic                         err_o
);
    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int ROB_W = IDX_W + 1;
    localparam int LQ_W  = $clog2(LQ_DEPTH) + 1;
    localparam int SQ_W  = $clog2(SQ_DEPTH) + 1;
    localparam int BQ_W  = $clog2(BQ_DEPTH) + 1;
    localparam logic [ID_W-1:0] ID_ONE = ID_W'(1);

    alloc_state_e    state_q, state_d;
    logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, target_q, target_d;
    logic [ROB_W-1:0] robCnt_q, robCnt_d;
    logic [LQ_W-1:0] lqCnt_q, lqCnt_d;
    logic [SQ_W-1:0] sqCnt_q, sqCnt_d;
    logic [BQ_W-1:0] bqCnt_q, bqCnt_d;
    logic            recovering_q, err_q, err_d;

    logic [ID_W-1:0] occupancy, tailPrev, squashTarget, squashDist, latchedDist;
    logic            squashLegal, fire, commitOk, walk, ctrlErr, creditUnderflow;
    alloc_rec_t      wrRec, headRec, tailRec;
    int              lqNet, sqNet, bqNet;

    assign occupancy    = tail_q - head_q;
    assign tailPrev     = tail_q - ID_ONE;
    assign squashTarget = squash_id_i + ID_ONE;
    assign squashDist   = squashTarget - head_q;
    assign latchedDist  = target_q - head_q;
    assign squashLegal  = squashDist <= occupancy;
    assign commitOk     = commit_valid_i && (occupancy != '0);

    // No bypass of credits freed this cycle: ready looks only at registered counts.
    assign alloc_ready_o = (state_q == IDLE) && !squash_valid_i
                         && (robCnt_q < ROB_W'(ROB_DEPTH))
                         && (!alloc_uses_lq_i || (lqCnt_q < LQ_W'(LQ_DEPTH)))
                         && (!alloc_uses_sq_i || (sqCnt_q < SQ_W'(SQ_DEPTH)))
                         && (!alloc_uses_bq_i || (bqCnt_q < BQ_W'(BQ_DEPTH)));
    assign fire  = alloc_valid_i && alloc_ready_o;
    assign wrRec = '{lq: alloc_uses_lq_i, sq: alloc_uses_sq_i, bq: alloc_uses_bq_i};

    alloc_ring #(.DEPTH(ROB_DEPTH), .IDX_W(IDX_W)) u_ring (
        .clk       (clk),
        .wrEn_i    (fire),
        .wrIdx_i   (tail_q[IDX_W-1:0]),
        .wrData_i  (wrRec),
        .headIdx_i (head_q[IDX_W-1:0]),
        .headRec_o (headRec),
        .tailIdx_i (tailPrev[IDX_W-1:0]),
        .tailRec_o (tailRec)
    );

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        target_d = target_q;
        walk     = 1'b0;
        ctrlErr  = 1'b0;
        if (fire) begin
            tail_d = tail_q + ID_ONE;
            if (alloc_id_i != tail_q) ctrlErr = 1'b1;
        end
        if (commit_valid_i) begin
            if (commitOk) head_d = head_q + ID_ONE;
            else          ctrlErr = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (squash_valid_i) begin
                    if (!squashLegal)                ctrlErr = 1'b1;
                    else if (squashTarget != tail_q) begin
                        state_d  = RECOVER;
                        target_d = squashTarget;
                    end
                end
            end
            RECOVER: begin
                if (squash_valid_i) begin
                    if (!squashLegal)                      ctrlErr = 1'b1;
                    else if (squashTarget == tail_q)       state_d = IDLE;
                    else if (squashDist < latchedDist)     target_d = squashTarget;
                end
                // A commit that reaches the walking tail means head overran the target.
                if (state_d == RECOVER) begin
                    if (tail_q == head_d) begin
                        state_d = IDLE;
                        ctrlErr = 1'b1;
                    end else begin
                        walk   = 1'b1;
                        tail_d = tailPrev;
                        if (tailPrev == target_d) begin
                            state_d = IDLE;
                        end else if (tailPrev == head_d) begin
                            state_d = IDLE;
                            ctrlErr = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lqNet = creditNet(int'(lqCnt_q), fire & alloc_uses_lq_i, commitOk & headRec.lq, walk & tailRec.lq);
        sqNet = creditNet(int'(sqCnt_q), fire & alloc_uses_sq_i, commitOk & headRec.sq, walk & tailRec.sq);
        bqNet = creditNet(int'(bqCnt_q), fire & alloc_uses_bq_i, commitOk & headRec.bq, walk & tailRec.bq);
        creditUnderflow = (lqNet < 0) || (sqNet < 0) || (bqNet < 0);
        lqCnt_d  = (lqNet < 0) ? '0 : LQ_W'(lqNet);
        sqCnt_d  = (sqNet < 0) ? '0 : SQ_W'(sqNet);
        bqCnt_d  = (bqNet < 0) ? '0 : BQ_W'(bqNet);
        robCnt_d = ROB_W'(tail_d - head_d);
        err_d    = err_q | ctrlErr | creditUnderflow;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            target_q     <= '0;
            robCnt_q     <= '0;
            lqCnt_q      <= '0;
            sqCnt_q      <= '0;
            bqCnt_q      <= '0;
            recovering_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            target_q     <= target_d;
            robCnt_q     <= robCnt_d;
            lqCnt_q      <= lqCnt_d;
            sqCnt_q      <= sqCnt_d;
            bqCnt_q      <= bqCnt_d;
            recovering_q <= (state_d == RECOVER);
            err_q        <= err_d;
        end
    end

    assign rob_cnt_o    = robCnt_q;
    assign lq_cnt_o     = lqCnt_q;
    assign sq_cnt_o     = sqCnt_q;
    assign bq_cnt_o     = bqCnt_q;
    assign recovering_o = recovering_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_dispatch_alloc_ctrl.sv
// Bench for dispatch_alloc_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_dispatch_alloc_ctrl;
    localparam int ID_W      = 8;
    localparam int ID_MOD    = 256;
    localparam int ROB_DEPTH = 32;
    localparam int LQ_DEPTH  = 8;
    localparam int SQ_DEPTH  = 8;
    localparam int BQ_DEPTH  = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            alloc_valid_i;
    logic [ID_W-1:0] alloc_id_i;
    logic            alloc_uses_lq_i, alloc_uses_sq_i, alloc_uses_bq_i;
    logic            alloc_ready_o;
    logic            commit_valid_i;
    logic            squash_valid_i;
    logic [ID_W-1:0] squash_id_i;
    logic [5:0]      rob_cnt_o;
    logic [3:0]      lq_cnt_o, sq_cnt_o, bq_cnt_o;
    logic            recovering_o;
    logic            err_o;

    dispatch_alloc_ctrl #(
        .ROB_DEPTH(ROB_DEPTH), .LQ_DEPTH(LQ_DEPTH), .SQ_DEPTH(SQ_DEPTH),
        .BQ_DEPTH(BQ_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_id_i      (alloc_id_i),
        .alloc_uses_lq_i (alloc_uses_lq_i),
        .alloc_uses_sq_i (alloc_uses_sq_i),
        .alloc_uses_bq_i (alloc_uses_bq_i),
        .alloc_ready_o   (alloc_ready_o),
        .commit_valid_i  (commit_valid_i),
        .squash_valid_i  (squash_valid_i),
        .squash_id_i     (squash_id_i),
        .rob_cnt_o       (rob_cnt_o),
        .lq_cnt_o        (lq_cnt_o),
        .sq_cnt_o        (sq_cnt_o),
        .bq_cnt_o        (bq_cnt_o),
        .recovering_o    (recovering_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: in-flight records oldest-first as {lq,sq,bq}.
    logic [2:0] recQ[$];
    int         mHead;
    bit         mRecover;
    int         mTarget;
    bit         mErr;

    bit lastReady;
    bit readySeenInWalk;
    int walkLen;
    int robMax;
    bit rAv, rUl, rUs, rUb, rCv, rSv;
    int rAid, rSid, rOcc;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int countFlag(input int bitPos);
        int n = 0;
        foreach (recQ[i]) if (recQ[i][bitPos]) n++;
        return n;
    endfunction

    function automatic int modelTail();
        return (mHead + recQ.size()) % ID_MOD;
    endfunction

    function automatic int distOf(input int id);
        return (id - mHead + ID_MOD) % ID_MOD;
    endfunction

    function automatic bit modelReady(input bit sv, input bit ul, input bit us, input bit ub);
        return !mRecover && !sv && (recQ.size() < ROB_DEPTH)
            && (!ul || countFlag(2) < LQ_DEPTH)
            && (!us || countFlag(1) < SQ_DEPTH)
            && (!ub || countFlag(0) < BQ_DEPTH);
    endfunction

    task automatic modelReset();
        recQ.delete();
        mHead    = 0;
        mRecover = 0;
        mTarget  = 0;
        mErr     = 0;
    endtask

    task automatic modelStep(input bit av, input int aid, input bit ul, input bit us, input bit ub,
                             input bit cv, input bit sv, input int sid);
        int  occ0    = recQ.size();
        int  tail0   = modelTail();
        bit  fire    = av && modelReady(sv, ul, us, ub);
        int  tgt     = (sid + 1) % ID_MOD;
        int  sDist   = distOf(tgt);
        int  lDist   = distOf(mTarget);
        bit  legal   = (sDist <= occ0);
        bit  walkNow = 1;
        if (cv) begin
            if (occ0 != 0) begin
                void'(recQ.pop_front());
                mHead = (mHead + 1) % ID_MOD;
            end else begin
                mErr = 1;
            end
        end
        if (fire) begin
            if (aid != tail0) mErr = 1;
            recQ.push_back({ul, us, ub});
        end
        if (!mRecover) begin
            if (sv) begin
                if (!legal) mErr = 1;
                else if (sDist != occ0) begin
                    mRecover = 1;
                    mTarget  = tgt;
                end
            end
        end else begin
            if (sv) begin
                if (!legal) mErr = 1;
                else if (sDist == occ0) begin
                    mRecover = 0;
                    walkNow  = 0;
                end else if (sDist < lDist) mTarget = tgt;
            end
            if (walkNow) begin
                if (recQ.size() == 0) begin
                    mRecover = 0;
                    mErr     = 1;
                end else begin
                    void'(recQ.pop_back());
                    if (modelTail() == mTarget) mRecover = 0;
                    else if (recQ.size() == 0) begin
                        mRecover = 0;
                        mErr     = 1;
                    end
                end
            end
        end
    endtask

    task automatic checkState();
        checkOutput("robCnt", int'(rob_cnt_o), recQ.size());
        checkOutput("lqCnt", int'(lq_cnt_o), countFlag(2));
        checkOutput("sqCnt", int'(sq_cnt_o), countFlag(1));
        checkOutput("bqCnt", int'(bq_cnt_o), countFlag(0));
        checkOutput("recovering", int'(recovering_o), int'(mRecover));
        checkOutput("err", int'(err_o), int'(mErr));
    endtask

    task automatic applyStimulus(input bit av, input int aid, input bit ul, input bit us, input bit ub,
                                 input bit cv, input bit sv, input int sid);
        @(negedge clk);
        alloc_valid_i   = av;
        alloc_id_i      = ID_W'(aid);
        alloc_uses_lq_i = ul;
        alloc_uses_sq_i = us;
        alloc_uses_bq_i = ub;
        commit_valid_i  = cv;
        squash_valid_i  = sv;
        squash_id_i     = ID_W'(sid);
        #1;
        lastReady = alloc_ready_o;
        checkOutput("allocReady", int'(alloc_ready_o), int'(modelReady(sv, ul, us, ub)));
        @(posedge clk);
        modelStep(av, aid, ul, us, ub, cv, sv, sid);
        #1;
        checkState();
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn            = 1'b0;
        alloc_valid_i   = 1'b0;
        commit_valid_i  = 1'b0;
        squash_valid_i  = 1'b0;
        @(posedge clk);
        modelReset();
        #1;
        checkState();
        rstn = 1'b1;
    endtask

    task automatic allocOne(input bit ul, input bit us, input bit ub);
        applyStimulus(1, modelTail(), ul, us, ub, 0, 0, 0);
    endtask

    task automatic drainWalk(input bit probeAlloc);
        int guard = 0;
        walkLen = 0;
        readySeenInWalk = 0;
        while (recovering_o === 1'b1 && guard < 64) begin
            walkLen++;
            applyStimulus(probeAlloc, modelTail(), 0, 0, 0, 0, 0, 0);
            if (lastReady) readySeenInWalk = 1;
            guard++;
        end
        checkOutput("walkEnded", int'(recovering_o), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn            = 1'b0;
        alloc_valid_i   = 1'b0;
        alloc_id_i      = '0;
        alloc_uses_lq_i = 1'b0;
        alloc_uses_sq_i = 1'b0;
        alloc_uses_bq_i = 1'b0;
        commit_valid_i  = 1'b0;
        squash_valid_i  = 1'b0;
        squash_id_i     = '0;
        modelReset();

        $display("[TB] load queue exhaustion");
        doReset();
        checkOutput("resetRob", int'(rob_cnt_o), 0);
        checkOutput("resetErr", int'(err_o), 0);
        for (int i = 0; i < 8; i++) allocOne(1, 0, 0);
        checkOutput("lqFull", int'(lq_cnt_o), 8);
        applyStimulus(1, modelTail(), 1, 0, 0, 0, 0, 0);
        checkOutput("ninthLoadReady", int'(lastReady), 0);
        allocOne(0, 0, 0);
        checkOutput("nonLoadReady", int'(lastReady), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("lqAfterCommit", int'(lq_cnt_o), 7);
        allocOne(1, 0, 0);
        checkOutput("loadAfterCommit", int'(lastReady), 1);

        $display("[TB] ROB full with concurrent commit");
        doReset();
        for (int i = 0; i < 32; i++) allocOne(0, 0, 0);
        checkOutput("robFull", int'(rob_cnt_o), 32);
        robMax = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, modelTail(), 0, 0, 0, 1, 0, 0);
            if (int'(rob_cnt_o) > robMax) robMax = int'(rob_cnt_o);
        end
        checkOutput("robNeverOver", int'(robMax <= 32), 1);
        checkOutput("robFullErr", int'(err_o), 0);

        $display("[TB] squash walk with store/branch records");
        doReset();
        for (int i = 0; i < 10; i++) allocOne(0, (i == 5 || i == 7), (i == 3));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
        drainWalk(1);
        checkOutput("walkLen", walkLen, 6);
        checkOutput("readyDuringWalk", int'(readySeenInWalk), 0);
        checkOutput("tailAfterWalk", int'(rob_cnt_o), 4);
        checkOutput("sqAfterWalk", int'(sq_cnt_o), 0);
        checkOutput("bqAfterWalk", int'(bq_cnt_o), 1);

        $display("[TB] retarget during walk");
        doReset();
        for (int i = 0; i < 10; i++) allocOne(i[0], 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 8);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
        drainWalk(0);
        checkOutput("retargetTail", int'(rob_cnt_o), 5);
        checkOutput("retargetErr", int'(err_o), 0);

        $display("[TB] flush everything, then commit racing the walk");
        doReset();
        for (int i = 0; i < 7; i++) allocOne(1, 0, i[0]);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, (mHead + ID_MOD - 1) % ID_MOD);
        drainWalk(0);
        checkOutput("flushAllLen", walkLen, 5);
        checkOutput("flushAllRob", int'(rob_cnt_o), 0);
        checkOutput("flushAllLq", int'(lq_cnt_o), 0);
        for (int i = 0; i < 5; i++) allocOne(0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, (mHead + ID_MOD - 1) % ID_MOD);
        drainWalk(0);
        checkOutput("raceErr", int'(err_o), 1);
        checkOutput("raceRob", int'(rob_cnt_o), 0);
        checkOutput("raceSq", int'(sq_cnt_o), 0);

        $display("[TB] reset in the middle of a walk");
        doReset();
        for (int i = 0; i < 6; i++) allocOne(1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        doReset();
        checkOutput("midResetRob", int'(rob_cnt_o), 0);
        checkOutput("midResetLq", int'(lq_cnt_o), 0);
        checkOutput("midResetRec", int'(recovering_o), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("grantId0", int'(lastReady), 1);
        checkOutput("grantId0Rob", int'(rob_cnt_o), 1);

        $display("[TB] random traffic");
        for (int round = 0; round < 4; round++) begin
            doReset();
            for (int c = 0; c < 500; c++) begin
                rOcc = recQ.size();
                rAv  = ($urandom_range(0, 3) != 0);
                rAid = modelTail();
                if (round == 3 && $urandom_range(0, 30) == 0) rAid = (rAid + 1) % ID_MOD;
                rUl  = ($urandom_range(0, 2) == 0);
                rUs  = ($urandom_range(0, 2) == 0);
                rUb  = ($urandom_range(0, 3) == 0);
                rCv  = ($urandom_range(0, 2) == 0);
                rSv  = ($urandom_range(0, 15) == 0);
                rSid = (mHead + int'($urandom_range(0, rOcc)) - 1 + ID_MOD) % ID_MOD;
                if (round == 3 && $urandom_range(0, 1) == 0) rSid = int'($urandom_range(0, ID_MOD - 1));
                if (round != 3) begin
                    if (rOcc == 0) rCv = 0;
                    if (mRecover && distOf(mTarget) == 0) rCv = 0;
                    if (rSv && distOf((rSid + 1) % ID_MOD) == 0) rCv = 0;
                end
                applyStimulus(rAv, rAid, rUl, rUs, rUb, rCv, rSv, rSid);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
